// File: rtl/lshift_seq_pkg.sv
// Shared FPU definitions for the multi-cycle scale-up unit.
// Provides the FP32 field helpers, the special exponent values, the FPU
// op-code constants and the IDLE/SHIFT/DONE state encoding used by
// lshift_seq and fp_double_step.
// Optional build macro seen by users of this package: LSHIFT_SAT_EN.
package lshift_seq_pkg;

    localparam logic [7:0] EXP_INF     = 8'hFF;
    localparam logic [7:0] EXP_MAX_FIN = 8'hFE;

    localparam logic [3:0] OP_LSHIFT = 4'd7;
    localparam logic [3:0] OP_RSHIFT = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic fp_sign(input logic [31:0] v);
        return v[31];
    endfunction

    function automatic logic [7:0] fp_exp(input logic [31:0] v);
        return v[30:23];
    endfunction

    function automatic logic [22:0] fp_man(input logic [31:0] v);
        return v[22:0];
    endfunction

endpackage

// File: rtl/lshift_seq_fp_double_step.sv
// fp_double_step: combinational single doubling of an FP32 value.
// Ports:
//   val_in   in  32  value to double (never Inf/NaN or zero when used)
//   val_out  out 32  doubled value
//   ovf      out 1   doubling left the finite range
// Build macro LSHIFT_SAT_EN: when defined an overflowing step saturates to
// the largest finite magnitude, otherwise it produces infinity.
module fp_double_step
    import lshift_seq_pkg::*;
(
    input  logic [31:0] val_in,
    output logic [31:0] val_out,
    output logic        ovf
);

    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;

    assign sign = fp_sign(val_in);
    assign exp  = fp_exp(val_in);
    assign man  = fp_man(val_in);

    always_comb begin
        val_out = val_in;
        ovf     = 1'b0;
        if (exp == 8'd0) begin
            // Denormal: shifting the mantissa up carries its top bit into
            // the exponent field, so a leading 1 turns it into exp=1.
            val_out = {sign, 7'd0, man[22], man[21:0], 1'b0};
        end else if (exp == EXP_MAX_FIN) begin
            ovf = 1'b1;
`ifdef LSHIFT_SAT_EN
            val_out = {sign, EXP_MAX_FIN, 23'h7FFFFF};
`else
            val_out = {sign, EXP_INF, 23'd0};
`endif
        end else if (exp != EXP_INF) begin
            val_out = {sign, exp + 8'd1, man};
        end
    end

endmodule

// File: rtl/lshift_seq.sv
// lshift_seq: multi-cycle FP32 scale-up, result = a * 2^shamt, one doubling
// per clock, with valid/ready handshakes on input and output.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   in_valid / in_ready    request handshake (in_ready high only in IDLE)
//   a, operation, shamt    operand, FPU op code (must equal OP_CODE), doublings
//   lshift_out, Overflow   result and overflow flag, stable while out_valid
//   out_valid / out_ready  result handshake
// Build macro LSHIFT_SAT_EN selects saturation instead of infinity on overflow.
module lshift_seq
    import lshift_seq_pkg::*;
#(
    parameter logic [3:0] OP_CODE = OP_LSHIFT,
    parameter int         SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        a,
    input  logic [3:0]         operation,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [31:0]        lshift_out,
    output logic               Overflow,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

    state_t             state_q, state_d;
    logic [31:0]        val_q, val_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [31:0]        step_val;
    logic               step_ovf;
    logic               early_done;

    fp_double_step u_step (
        .val_in  (val_q),
        .val_out (step_val),
        .ovf     (step_ovf)
    );

    // Zero shift, Inf/NaN and signed zero need no work and skip SHIFT.
    assign early_done = (shamt == '0) || (fp_exp(a) == EXP_INF) || (a[30:0] == 31'd0);

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && (operation == OP_CODE)) begin
                    val_d   = a;
                    cnt_d   = shamt;
                    ovf_d   = 1'b0;
                    state_d = early_done ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                val_d = step_val;
                cnt_d = cnt_q - CNT_ONE;
                if (step_ovf) begin
                    ovf_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            val_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign lshift_out = val_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_lshift_seq.sv
// Testbench for lshift_seq: directed cases plus randomized requests checked
// against a value-level reference model of a * 2^shamt.
module tb_lshift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [3:0]  operation;
    logic [4:0]  shamt;
    logic [31:0] lshift_out;
    logic        Overflow;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    lshift_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .operation  (operation),
        .shamt      (shamt),
        .lshift_out (lshift_out),
        .Overflow   (Overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Reference: treats the operand as sign/exponent/significand and scales
    // the value directly, counting how many doublings the unit must perform.
    task automatic refModel(input logic [31:0] av, input int n_in,
                            output logic [31:0] res, output logic ovf, output int lat);
        logic        s;
        int          e;
        logic [31:0] m;
        int          n;
        int          steps;
        int          p;
        s = av[31];
        e = int'(av[30:23]);
        m = {9'd0, av[22:0]};
        n = n_in;
        ovf = 1'b0;
        res = av;
        lat = 1;
        if (n == 0 || e == 255 || av[30:0] == 31'd0) return;
        steps = 0;
        if (e == 0) begin
            p = 0;
            for (int i = 0; i < 23; i++) if (m[i]) p = i;
            if (n < 23 - p) begin
                m = m << n;
                res = {s, 8'd0, m[22:0]};
                lat = n + 1;
                return;
            end
            steps = 23 - p;
            m = m << steps;
            e = 1;
            n = n - steps;
        end
        if (n <= 254 - e) begin
            res = {s, 8'(e + n), m[22:0]};
            lat = steps + n + 1;
        end else begin
            ovf = 1'b1;
`ifdef LSHIFT_SAT_EN
            res = {s, 8'hFE, 23'h7FFFFF};
`else
            res = {s, 8'hFF, 23'd0};
`endif
            lat = steps + (255 - e) + 1;
        end
    endtask

    // Presents one request, then counts cycles until out_valid (bounded).
    task automatic applyStimulus(input logic [31:0] av, input logic [4:0] sh, output int lat);
        @(negedge clk);
        check32("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = av;
        shamt     = sh;
        operation = 4'd7;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Compares the finished result against the model, then completes the
    // output handshake and confirms the unit went idle.
    task automatic checkOutput(input string tag, input logic [31:0] av, input logic [4:0] sh,
                               input int lat);
        logic [31:0] exp_res;
        logic        exp_ovf;
        int          exp_lat;
        refModel(av, int'(sh), exp_res, exp_ovf, exp_lat);
        check32({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        check32({tag, "_result"}, lshift_out, exp_res);
        check32({tag, "_overflow"}, {31'd0, Overflow}, {31'd0, exp_ovf});
        check32({tag, "_latency"}, lat, exp_lat);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check32({tag, "_idle_after"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    task automatic runOne(input string tag, input logic [31:0] av, input logic [4:0] sh);
        int lat;
        applyStimulus(av, sh, lat);
        checkOutput(tag, av, sh, lat);
    endtask

    initial begin
        int          lat;
        logic [31:0] held;
        logic [31:0] rv;
        logic [4:0]  rs;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        operation = 4'd0;
        shamt     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check32("reset_out", lshift_out, 32'd0);
        check32("reset_flags", {29'd0, Overflow, out_valid, in_ready}, 32'd1);

        runOne("one_x8", 32'h3F800000, 5'd3);
        runOne("denorm_s1", 32'h00400000, 5'd1);
        runOne("denorm_s2", 32'h00400000, 5'd2);
        runOne("ovf_neg", 32'hFF000000, 5'd2);
        runOne("neg_zero", 32'h80000000, 5'd5);
        runOne("nan_pass", 32'h7FC00000, 5'd5);
        runOne("shamt_zero", 32'h40490FDB, 5'd0);
        runOne("tiny_denorm", 32'h00000001, 5'd31);

        // Wrong op code must be ignored.
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'd8;
        a         = 32'h3F800000;
        shamt     = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("wrong_op_idle", {30'd0, out_valid, in_ready}, 32'd1);
        end
        in_valid = 1'b0;

        // Result must hold while the consumer stalls.
        applyStimulus(32'h3F800000, 5'd3, lat);
        held = lshift_out;
        check32("stall_first", held, 32'h41000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check32("stall_hold", lshift_out, 32'h41000000);
            check32("stall_flags", {30'd0, out_valid, in_ready}, 32'd2);
        end
        checkOutput("stall_release", 32'h3F800000, 5'd3, lat);

        // Reset in the middle of a long shift aborts it.
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'd7;
        a         = 32'h3F800000;
        shamt     = 5'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check32("mid_shift_busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check32("abort_flags", {29'd0, Overflow, out_valid, in_ready}, 32'd1);
        check32("abort_out", lshift_out, 32'd0);

        // Randomized requests spread over the interesting operand classes.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: rv = {1'($urandom), 8'($urandom_range(230, 254)), 23'($urandom)};
                1: rv = {1'($urandom), 8'd0, 23'($urandom) >> $urandom_range(0, 22)};
                2: rv = {1'($urandom), 8'($urandom_range(1, 200)), 23'($urandom)};
                3: rv = {1'($urandom), 8'hFF, 23'($urandom)};
                default: rv = {1'($urandom), 31'd0};
            endcase
            if (rv[30:23] == 8'd0 && rv[22:0] == 23'd0 && k[0]) rv[0] = 1'b1;
            rs = 5'($urandom);
            runOne("random", rv, rs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
